// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the level sequencer.
package game_pkg;

  // Encoded game-flow state; also exported for the banner display.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    PLAY      = 3'd2,
    WIN_HOLD  = 3'd3,
    LOSE_HOLD = 3'd4,
    GAME_OVER = 3'd5,
    VICTORY   = 3'd6
  } game_state_t;

  // Two-second banner hold at the 25 MHz pixel clock.
  localparam int PAUSE_2S_25MHZ = 50_000_000;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_edge_detector.sv
// Two-flop synchroniser plus registered rising-edge pulse for a push button.
// The pulse appears 3 clocks after the raw input rises and is one clock wide.
module button_edge_detector (
  input  logic vga_clock,
  input  logic reset,
  input  logic button,
  output logic rise
);

  logic sync1, sync2, sync3;

  // Synchronise, keep one delayed copy, and register the 0->1 transition.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: picks the active level, releases only its reset,
// and turns win/lose flags into lives accounting, banner holds and advance.
// Optional feature: define LEVEL_SEQUENCER_SKIP_EN to add skip_button, whose
// edge in PLAY acts as a win of the active level.
module level_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LEVELS   = 3,
  parameter int LIVES        = 3,
  parameter int LIVES_W      = 2,
  parameter int LOAD_CYCLES  = 2,
  parameter int PAUSE_CYCLES = PAUSE_2S_25MHZ,
  localparam int SEL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int TIMER_W     = imax(1, $clog2(imax(PAUSE_CYCLES, LOAD_CYCLES)))
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  start_button,
`ifdef LEVEL_SEQUENCER_SKIP_EN
  input  logic                  skip_button,
`endif
  input  logic [NUM_LEVELS-1:0] level_win,
  input  logic [NUM_LEVELS-1:0] level_lose,
  output logic [NUM_LEVELS-1:0] level_reset_n,
  output logic [SEL_W-1:0]      level_sel,
  output logic                  play_enable,
  output logic [LIVES_W-1:0]    lives,
  output logic [2:0]            game_state
);

  localparam logic [TIMER_W-1:0] LOAD_LAST  = TIMER_W'(LOAD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PAUSE_LAST = TIMER_W'(PAUSE_CYCLES - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  game_state_t          state, state_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic [LIVES_W-1:0]   lives_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic                 start_rise;
  logic                 win_play, lose_play;
  logic [NUM_LEVELS-1:0] rst_vec_nxt;
  logic                 live_nxt;

  button_edge_detector u_start (
    .vga_clock (vga_clock),
    .reset     (reset),
    .button    (start_button),
    .rise      (start_rise)
  );

  // Only the active level's flags matter; every other bit is ignored.
`ifdef LEVEL_SEQUENCER_SKIP_EN
  logic skip_rise;

  button_edge_detector u_skip (
    .vga_clock (vga_clock),
    .reset     (reset),
    .button    (skip_button),
    .rise      (skip_rise)
  );

  assign win_play = level_win[level_sel] | skip_rise;
`else
  assign win_play = level_win[level_sel];
`endif
  assign lose_play = level_lose[level_sel];

  // Next-state, level/lives bookkeeping and the shared phase timer.
  always_comb begin
    state_nxt = state;
    sel_nxt   = level_sel;
    lives_nxt = lives;
    timer_nxt = timer + TIMER_W'(1);
    case (state)
      IDLE, GAME_OVER, VICTORY: begin
        timer_nxt = '0;
        if (start_rise) begin
          state_nxt = LOAD;
          sel_nxt   = '0;
          lives_nxt = LIVES_INIT;
        end
      end
      LOAD: begin
        if (timer == LOAD_LAST) state_nxt = PLAY;
      end
      PLAY: begin
        timer_nxt = '0;
        // Win takes priority over a simultaneous lose.
        if (win_play)       state_nxt = WIN_HOLD;
        else if (lose_play) state_nxt = LOSE_HOLD;
      end
      WIN_HOLD: begin
        if (timer == PAUSE_LAST) begin
          if (level_sel == SEL_LAST) begin
            state_nxt = VICTORY;
          end else begin
            state_nxt = LOAD;
            sel_nxt   = level_sel + SEL_W'(1);
          end
        end
      end
      LOSE_HOLD: begin
        if (timer == PAUSE_LAST) begin
          // Guard against zero as well so lives can never wrap.
          if (lives <= LIVES_W'(1)) begin
            state_nxt = GAME_OVER;
            lives_nxt = '0;
          end else begin
            state_nxt = LOAD;
            lives_nxt = lives - LIVES_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
    if (state_nxt != state) timer_nxt = '0;
  end

  // Decode the reset vector from the next state so it lines up with state.
  // The level stays live through the holds so its last frame stays on screen.
  assign live_nxt = (state_nxt == PLAY) || (state_nxt == WIN_HOLD) ||
                    (state_nxt == LOSE_HOLD);

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_rst
    assign rst_vec_nxt[i] = live_nxt && (sel_nxt == SEL_W'(i));
  end

  // Game-flow registers and registered per-level resets.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      level_sel     <= '0;
      lives         <= LIVES_INIT;
      timer         <= '0;
      level_reset_n <= '0;
    end else begin
      state         <= state_nxt;
      level_sel     <= sel_nxt;
      lives         <= lives_nxt;
      timer         <= timer_nxt;
      level_reset_n <= rst_vec_nxt;
    end
  end

  assign play_enable = (state == PLAY);
  assign game_state  = state;

endmodule
